// File: rtl/hazard_pkg.sv
// Shared defaults, slot-0 reset placement and FSM state type for the hazard scheduler.
package hazard_pkg;

    localparam int N_SLOTS_DEF     = 4;
    localparam int SPRITE_SZ_DEF   = 12;
    localparam int HOLD_FRAMES_DEF = 60;

    localparam logic [9:0] SLOT0_X = 10'd180;
    localparam logic [9:0] SLOT0_Y = 10'd36;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HIT  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/hazard_overlap.sv
// Inclusive axis-aligned box overlap between the character and one hazard.
module hazard_overlap
    import hazard_pkg::*;
#(
    parameter int SPRITE_SZ = SPRITE_SZ_DEF
) (
    input  logic [9:0] i_char_x,
    input  logic [9:0] i_char_y,
    input  logic [9:0] i_haz_x,
    input  logic [9:0] i_haz_y,
    output logic       o_hit
);

    localparam logic [10:0] SZ = 11'(SPRITE_SZ);

    logic w_x_ok;
    logic w_y_ok;

    // 11-bit sums so a box near the right/bottom edge never wraps to a false hit
    assign w_x_ok = ({1'b0, i_char_x} <= {1'b0, i_haz_x} + SZ) &&
                    ({1'b0, i_haz_x}  <= {1'b0, i_char_x} + SZ);
    assign w_y_ok = ({1'b0, i_char_y} <= {1'b0, i_haz_y} + SZ) &&
                    ({1'b0, i_haz_y}  <= {1'b0, i_char_y} + SZ);
    assign o_hit  = w_x_ok && w_y_ok;

endmodule

// File: rtl/hazard_sched.sv
// Per-frame hazard collision scan with death pulse and frame-counted lockout.
//   state | meaning
//   IDLE  | waiting for frame_tick
//   SCAN  | testing one slot per cycle, lowest index first
//   HIT   | one-cycle death pulse, clears the hitting slot
//   HOLD  | dead; counts frame ticks down to zero
module hazard_sched
    import hazard_pkg::*;
#(
    parameter int N_SLOTS     = N_SLOTS_DEF,
    parameter int SPRITE_SZ   = SPRITE_SZ_DEF,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
    parameter int IW          = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic          sys_clk,
    input  logic          RST,
    input  logic          frame_tick,
    input  logic [9:0]    char_X,
    input  logic [9:0]    char_Y,
    input  logic [9:0]    bg_pos,
    input  logic          slot_wr_en,
    input  logic [IW-1:0] slot_wr_idx,
    input  logic [9:0]    slot_wr_x,
    input  logic [9:0]    slot_wr_y,
    input  logic          slot_wr_act,
    input  logic [IW-1:0] slot_rd_idx,
    output logic [9:0]    slot_rd_x,
    output logic [9:0]    slot_rd_y,
    output logic          slot_rd_en,
    output logic          death,
    output logic          dead,
    output logic [IW-1:0] hit_idx,
    output logic          busy
);

    localparam int CW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [IW-1:0]       r_idx;
    logic [CW-1:0]       r_cnt;
    logic                r_dead;
    logic [IW-1:0]       r_hit_idx;
    logic [9:0]          r_x [N_SLOTS];
    logic [9:0]          r_y [N_SLOTS];
    logic [N_SLOTS-1:0]  r_act;

    logic w_overlap;
    logic w_hit;
    logic w_last;
    logic w_cnt_end;

    hazard_overlap #(
        .SPRITE_SZ (SPRITE_SZ)
    ) u_overlap (
        .i_char_x (char_X),
        .i_char_y (char_Y),
        .i_haz_x  (r_x[r_idx]),
        .i_haz_y  (r_y[r_idx]),
        .o_hit    (w_overlap)
    );

    assign w_hit     = r_act[r_idx] && w_overlap;
    assign w_last    = (r_idx == IW'(N_SLOTS - 1));
    assign w_cnt_end = (r_cnt <= CW'(1));

    always_ff @(posedge sys_clk or posedge RST) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (frame_tick) w_next = ST_SCAN;
            ST_SCAN: begin
                if (w_hit)       w_next = ST_HIT;
                else if (w_last) w_next = ST_IDLE;
            end
            ST_HIT:  w_next = ST_HOLD;
            ST_HOLD: if (frame_tick && w_cnt_end) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge RST) begin
        if (RST) begin
            r_idx     <= '0;
            r_cnt     <= '0;
            r_dead    <= 1'b0;
            r_hit_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (frame_tick) r_idx <= '0;
                ST_SCAN: if (!w_hit) r_idx <= w_last ? '0 : r_idx + 1'b1;
                ST_HIT: begin
                    r_hit_idx <= r_idx;
                    r_dead    <= 1'b1;
                    r_cnt     <= CW'(HOLD_FRAMES);
                end
                ST_HOLD: begin
                    if (frame_tick) begin
                        r_cnt <= w_cnt_end ? '0 : r_cnt - 1'b1;
                        if (w_cnt_end) r_dead <= 1'b0;
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

    // The config write comes after the hit clear so a same-slot write survives
    always_ff @(posedge sys_clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r_x[i]   <= (i == 0) ? SLOT0_X : 10'd0;
                r_y[i]   <= (i == 0) ? SLOT0_Y : 10'd0;
                r_act[i] <= (i == 0);
            end
        end else begin
            if (r_state == ST_HIT) r_act[r_idx] <= 1'b0;
            if (slot_wr_en) begin
                r_x[slot_wr_idx]   <= slot_wr_x;
                r_y[slot_wr_idx]   <= slot_wr_y;
                r_act[slot_wr_idx] <= slot_wr_act;
            end
        end
    end

    assign slot_rd_x  = r_x[slot_rd_idx] - bg_pos;
    assign slot_rd_y  = r_y[slot_rd_idx];
    assign slot_rd_en = r_act[slot_rd_idx];
    assign death      = (r_state == ST_HIT);
    assign busy       = (r_state == ST_SCAN) || (r_state == ST_HIT);
    assign dead       = r_dead;
    assign hit_idx    = r_hit_idx;

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: boundary table, hand-written corner sequences, random run vs reference model.
module tb_hazard_sched;

    localparam int N  = 4;
    localparam int SZ = 12;
    localparam int HF = 3;

    logic       sys_clk;
    logic       RST;
    logic       frame_tick;
    logic [9:0] char_X, char_Y, bg_pos;
    logic       slot_wr_en;
    logic [1:0] slot_wr_idx;
    logic [9:0] slot_wr_x, slot_wr_y;
    logic       slot_wr_act;
    logic [1:0] slot_rd_idx;
    logic [9:0] slot_rd_x, slot_rd_y;
    logic       slot_rd_en, death, dead, busy;
    logic [1:0] hit_idx;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_sched #(
        .N_SLOTS     (N),
        .SPRITE_SZ   (SZ),
        .HOLD_FRAMES (HF)
    ) dut (
        .sys_clk     (sys_clk),
        .RST         (RST),
        .frame_tick  (frame_tick),
        .char_X      (char_X),
        .char_Y      (char_Y),
        .bg_pos      (bg_pos),
        .slot_wr_en  (slot_wr_en),
        .slot_wr_idx (slot_wr_idx),
        .slot_wr_x   (slot_wr_x),
        .slot_wr_y   (slot_wr_y),
        .slot_wr_act (slot_wr_act),
        .slot_rd_idx (slot_rd_idx),
        .slot_rd_x   (slot_rd_x),
        .slot_rd_y   (slot_rd_y),
        .slot_rd_en  (slot_rd_en),
        .death       (death),
        .dead        (dead),
        .hit_idx     (hit_idx),
        .busy        (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge sys_clk);
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic write_slot(input int idx, input int x, input int y, input bit act);
        slot_wr_en  = 1'b1;
        slot_wr_idx = 2'(idx);
        slot_wr_x   = 10'(x);
        slot_wr_y   = 10'(y);
        slot_wr_act = act;
        cyc();
        slot_wr_en  = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        frame_tick = 1'b0;
        slot_wr_en = 1'b0;
        slot_wr_idx = '0; slot_wr_x = '0; slot_wr_y = '0; slot_wr_act = 1'b0;
        slot_rd_idx = '0; bg_pos = '0;
        cyc();
        cyc();
        RST = 1'b0;
        cyc();
    endtask

    // Reference model: slot contents plus a per-frame timeline
    int m_x [N];
    int m_y [N];
    bit m_act [N];
    int m_scan;        // slot to be tested this cycle, -1 when not scanning
    bit m_hitnow;
    int m_hitslot;
    int m_hold_left;
    bit m_dead;
    int m_hit_idx;

    function automatic bit ovl(input int cx, input int cy, input int hx, input int hy);
        return (cx <= hx + SZ) && (hx <= cx + SZ) && (cy <= hy + SZ) && (hy <= cy + SZ);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = (i == 0) ? 180 : 0;
            m_y[i] = (i == 0) ? 36 : 0;
            m_act[i] = (i == 0);
        end
        m_scan = -1; m_hitnow = 0; m_hitslot = 0;
        m_hold_left = 0; m_dead = 0; m_hit_idx = 0;
    endtask

    task automatic model_step();
        if (m_hitnow) begin
            m_act[m_hitslot] = 0;
            m_hit_idx = m_hitslot;
            m_dead = 1;
            m_hold_left = HF;
            m_hitnow = 0;
        end else if (m_scan >= 0) begin
            if (m_act[m_scan] && ovl(int'(char_X), int'(char_Y), m_x[m_scan], m_y[m_scan])) begin
                m_hitnow = 1;
                m_hitslot = m_scan;
                m_scan = -1;
            end else begin
                m_scan++;
                if (m_scan == N) m_scan = -1;
            end
        end else if (m_dead) begin
            if (frame_tick) begin
                m_hold_left--;
                if (m_hold_left <= 0) m_dead = 0;
            end
        end else if (frame_tick) begin
            m_scan = 0;
        end
        if (slot_wr_en) begin
            m_x[slot_wr_idx] = int'(slot_wr_x);
            m_y[slot_wr_idx] = int'(slot_wr_y);
            m_act[slot_wr_idx] = slot_wr_act;
        end
    endtask

    task automatic model_check();
        int r;
        r = int'(slot_rd_idx);
        chk("rnd_busy", int'(busy), int'((m_scan >= 0) || m_hitnow));
        chk("rnd_death", int'(death), int'(m_hitnow));
        chk("rnd_dead", int'(dead), int'(m_dead));
        chk("rnd_hit_idx", int'(hit_idx), m_hit_idx);
        chk("rnd_rd_x", int'(slot_rd_x), (m_x[r] - int'(bg_pos)) & 1023);
        chk("rnd_rd_y", int'(slot_rd_y), m_y[r]);
        chk("rnd_rd_en", int'(slot_rd_en), int'(m_act[r]));
    endtask

    typedef struct {
        int cx;
        int cy;
        bit exp_death;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int nb, nd;
        bit prev_tick;

        vecs[0] = '{192, 48, 1'b1};
        vecs[1] = '{193, 36, 1'b0};
        vecs[2] = '{1020, 36, 1'b0};
        vecs[3] = '{190, 40, 1'b1};
        vecs[4] = '{168, 24, 1'b1};
        vecs[5] = '{167, 36, 1'b0};
        vecs[6] = '{180, 49, 1'b0};
        vecs[7] = '{300, 200, 1'b0};

        char_X = '0; char_Y = '0;
        do_reset();

        chk("rst_busy", int'(busy), 0);
        chk("rst_dead", int'(dead), 0);
        chk("rst_death", int'(death), 0);
        chk("rst_hit_idx", int'(hit_idx), 0);
        chk("rst_s0_x", int'(slot_rd_x), 180);
        chk("rst_s0_y", int'(slot_rd_y), 36);
        chk("rst_s0_en", int'(slot_rd_en), 1);
        slot_rd_idx = 2'd1; #1;
        chk("rst_s1_en", int'(slot_rd_en), 0);
        chk("rst_s1_x", int'(slot_rd_x), 0);

        // Single-slot boundary table against the reset slot 0 at (180,36)
        for (int i = 0; i < 8; i++) begin
            do_reset();
            char_X = 10'(vecs[i].cx);
            char_Y = 10'(vecs[i].cy);
            pulse_tick();
            cyc();
            chk($sformatf("tbl%0d_death", i), int'(death), int'(vecs[i].exp_death));
            cyc();
            chk($sformatf("tbl%0d_dead", i), int'(dead), int'(vecs[i].exp_death));
            chk($sformatf("tbl%0d_s0_en", i), int'(slot_rd_en), int'(!vecs[i].exp_death));
            chk($sformatf("tbl%0d_death_gone", i), int'(death), 0);
        end

        // Miss: exactly N busy cycles, no death
        do_reset();
        char_X = 10'd300; char_Y = 10'd200;
        pulse_tick();
        nb = 0; nd = 0;
        repeat (8) begin
            nb += int'(busy);
            nd += int'(death);
            cyc();
        end
        chk("miss_busy_cycles", nb, 4);
        chk("miss_deaths", nd, 0);
        chk("miss_idle", int'(busy), 0);

        // Hit on slot 0 then countdown of the lockout
        do_reset();
        char_X = 10'd190; char_Y = 10'd40;
        pulse_tick();
        chk("hit_no_early_death", int'(death), 0);
        cyc();
        chk("hit_death", int'(death), 1);
        cyc();
        chk("hit_dead", int'(dead), 1);
        chk("hit_idx0", int'(hit_idx), 0);
        chk("hit_s0_cleared", int'(slot_rd_en), 0);
        char_X = 10'd300; char_Y = 10'd200;
        pulse_tick();
        chk("hold_t1_dead", int'(dead), 1);
        pulse_tick();
        chk("hold_t2_dead", int'(dead), 1);
        pulse_tick();
        chk("hold_t3_dead", int'(dead), 0);
        chk("hold_t3_no_scan", int'(busy), 0);
        pulse_tick();
        chk("hold_t4_scan", int'(busy), 1);

        // Lowest index wins, later slot untouched
        do_reset();
        write_slot(1, 100, 100, 1'b1);
        write_slot(2, 100, 100, 1'b1);
        char_X = 10'd105; char_Y = 10'd105;
        pulse_tick();
        cyc();
        chk("prio_death", int'(death), 0);
        cyc();
        chk("prio_death2", int'(death), 1);
        cyc();
        chk("prio_hit_idx", int'(hit_idx), 1);
        slot_rd_idx = 2'd2; #1;
        chk("prio_s2_en", int'(slot_rd_en), 1);
        slot_rd_idx = 2'd1; #1;
        chk("prio_s1_en", int'(slot_rd_en), 0);

        // Write to the hit slot during HIT survives the clear
        do_reset();
        char_X = 10'd190; char_Y = 10'd40;
        pulse_tick();
        cyc();
        chk("wrhit_death", int'(death), 1);
        write_slot(0, 500, 500, 1'b1);
        chk("wrhit_s0_en", int'(slot_rd_en), 1);
        chk("wrhit_s0_x", int'(slot_rd_x), 500);
        chk("wrhit_dead", int'(dead), 1);

        // Scroll wrap on read and reset abandoning HOLD
        do_reset();
        bg_pos = 10'd200; #1;
        chk("scroll_rd_x", int'(slot_rd_x), 1004);
        chk("scroll_rd_y", int'(slot_rd_y), 36);
        bg_pos = 10'd0;
        char_X = 10'd190; char_Y = 10'd40;
        pulse_tick();
        cyc();
        cyc();
        pulse_tick();
        chk("midhold_dead", int'(dead), 1);
        RST = 1'b1; #1;
        chk("async_rst_dead", int'(dead), 0);
        chk("async_rst_busy", int'(busy), 0);
        cyc();
        RST = 1'b0;
        cyc();
        chk("rst_hold_s0_x", int'(slot_rd_x), 180);
        chk("rst_hold_s0_y", int'(slot_rd_y), 36);
        chk("rst_hold_s0_en", int'(slot_rd_en), 1);
        nd = 0;
        repeat (4) begin
            nd += int'(death) + int'(dead) + int'(busy);
            cyc();
        end
        chk("rst_hold_quiet", nd, 0);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        prev_tick = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge sys_clk);
            model_check();
            frame_tick  = (!prev_tick) && ($urandom_range(0, 5) == 0);
            prev_tick   = frame_tick;
            if ($urandom_range(0, 15) == 0) begin
                char_X = 10'($urandom_range(150, 230));
                char_Y = 10'($urandom_range(10, 70));
            end
            slot_wr_en  = ($urandom_range(0, 4) == 0);
            slot_wr_idx = 2'($urandom_range(0, 3));
            slot_wr_x   = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(1000, 1023))
                                                      : 10'($urandom_range(150, 230));
            slot_wr_y   = 10'($urandom_range(10, 70));
            slot_wr_act = ($urandom_range(0, 3) != 0);
            slot_rd_idx = 2'($urandom_range(0, 3));
            bg_pos      = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 299) == 0) begin
                RST = 1'b1;
                model_reset();
            end else begin
                RST = 1'b0;
                model_step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_sched.md
HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 SHALL have parameter N_SLOTS, default 4: number of hazard slots; slot index width IW = 2.
REQ-002 SHALL have parameter SPRITE_SZ, default 12: hazard and character box extent in pixels.
REQ-003 SHALL have parameter HOLD_FRAMES, default 60: frames of death lockout.
REQ-004 SHALL have port sys_clk  in  1: sole clock, rising edge.
REQ-005 SHALL have port RST  in  1: reset, asynchronous, active-high.
REQ-006 SHALL have port frame_tick  in  1: one-cycle pulse per video frame.
REQ-007 SHALL have ports char_X, char_Y  in  10: character top-left, world coordinates.
REQ-008 SHALL have port bg_pos  in  10: background scroll offset.
REQ-009 SHALL have ports slot_wr_en  in  1, slot_wr_idx  in  IW, slot_wr_x/slot_wr_y  in  10, slot_wr_act  in  1: slot configuration write.
REQ-010 SHALL have port slot_rd_idx  in  IW: render read select.
REQ-011 SHALL have ports slot_rd_x/slot_rd_y  out  10, slot_rd_en  out  1: screen position and enable of the selected slot.
REQ-012 SHALL have ports death  out  1 (one-cycle pulse), dead  out  1 (level), hit_idx  out  IW, busy  out  1.

Function
REQ-013 SHALL hold per-slot registers x, y (10 bits, world) and act (1 bit).
REQ-014 SHALL implement FSM IDLE, SCAN, HIT, HOLD; busy = 1 in SCAN and HIT.
REQ-015 IDLE: frame_tick SHALL move to SCAN with scan index 0; no other exit.
REQ-016 SCAN: one slot per cycle; an active, overlapping slot SHALL move to HIT, otherwise the index increments; after slot N_SLOTS-1 with no hit, return to IDLE (scan length N_SLOTS cycles).
REQ-017 Overlap SHALL be true when both axes satisfy char <= haz+SPRITE_SZ and haz <= char+SPRITE_SZ (inclusive), computed at 11 bits so sums never wrap.
REQ-018 Lowest-index hit SHALL win; slots after it are not evaluated that frame.
REQ-019 HIT (exactly one cycle): death = 1, hit_idx <= index, act[index] <= 0, dead <= 1, counter <= HOLD_FRAMES; next HOLD.
REQ-020 HOLD: each frame_tick SHALL decrement the counter; on the tick that reaches 0, dead <= 0 and return to IDLE that cycle (no scan on that tick).
REQ-021 frame_tick in SCAN or HIT SHALL be ignored.
REQ-022 A config write SHALL update x, y, act on the next edge in any state; a slot scanned in the same cycle is evaluated with its pre-write values.
REQ-023 A write coinciding with the HIT clear of the same slot SHALL win (write values retained).
REQ-024 slot_rd_x SHALL equal x - bg_pos modulo 1024, slot_rd_y = y, slot_rd_en = act; combinational, no latency.
REQ-025 death SHALL be 0 in every cycle other than HIT.

Reset
REQ-026 RST SHALL asynchronously force: state IDLE, scan index 0, counter 0, death 0, dead 0, hit_idx 0.
REQ-027 RST SHALL load slot 0 = (180, 36, act 1), all other slots = (0, 0, act 0).
REQ-028 RST mid-SCAN or mid-HOLD SHALL abandon the operation with no death pulse on release.

Structure
REQ-029 Package hazard_pkg SHALL hold N_SLOTS, SPRITE_SZ, HOLD_FRAMES defaults, the FSM state enum and slot-0 reset coordinates.
REQ-030 Box compare SHALL be a combinational sub-module hazard_overlap (char X/Y, hazard X/Y -> hit), instantiated once on the scanned slot.

Verification
REQ-031 After reset, char (300,200), frame_tick -> 4 busy cycles, no death, state IDLE.
REQ-032 Char (190,40), frame_tick -> death pulse 2 cycles after tick, hit_idx 0, dead 1, slot_rd_en(0) = 0.
REQ-033 Slots 1 and 2 written to (100,100) act 1, char (105,105) -> hit_idx 1, slot 2 stays active.
REQ-034 HOLD_FRAMES = 3 after a hit -> dead clears on the 3rd subsequent tick; the 4th tick starts a scan.
REQ-035 Char (192,48) vs slot 0 (180,36) -> hit (inclusive edge); char (193,36) -> no hit; char (1020,36) -> no hit.
REQ-036 bg_pos = 200, slot 0 x = 180 -> slot_rd_x = 1004; RST asserted mid-HOLD -> dead 0, slot 0 = (180,36) active.
